// File: rtl/qec_link_pkg.sv
// Shared definitions for the inter-board link serializer and deserializer:
// width derivations from the code distances and the link FSM state encoding.
package qec_link_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} link_state_e;

  function automatic int measurement_rounds(input int dx, input int dz);
    return (dx > dz) ? dx : dz;
  endfunction

  function automatic int address_width(input int dx, input int dz);
    return 3 * $clog2(measurement_rounds(dx, dz));
  endfunction

  function automatic int direct_message_width(input int dx, input int dz);
    return address_width(dx, dz) + 2;
  endfunction

  function automatic int master_fifo_width(input int dx, input int dz);
    return address_width(dx, dz) + 3;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pkt_w(input int mfw, input int n);
    return mfw + ch_w(n);
  endfunction

  function automatic int flits(input int pw, input int lw);
    return (pw + lw - 1) / lw;
  endfunction

endpackage

// File: rtl/master_link_serializer_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/master_link_serializer.sv
// Merges N arbitration-unit master FIFOs onto one link: round-robin pick, tag with
// the source channel, and emit the packet LSB-first as LINK_WIDTH-bit flits.
module master_link_serializer
  import qec_link_pkg::*;
#(
  parameter int CODE_DISTANCE_X = 5,
  parameter int CODE_DISTANCE_Z = 4,
  parameter int NUM_CHANNELS    = 4,
  parameter int LINK_WIDTH      = 8,
  localparam int MFW       = master_fifo_width(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int CH_W      = ch_w(NUM_CHANNELS),
  localparam int PKT_W     = pkt_w(MFW, NUM_CHANNELS),
  localparam int FLITS     = flits(PKT_W, LINK_WIDTH),
  localparam int PKT_EXT_W = FLITS * LINK_WIDTH,
  localparam int FC_W      = (FLITS > 1) ? $clog2(FLITS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CHANNELS*MFW-1:0]   ch_data,
  input  logic [NUM_CHANNELS-1:0]       ch_valid,
  output logic [NUM_CHANNELS-1:0]       ch_ready,
  output logic [LINK_WIDTH-1:0]         link_data,
  output logic                          link_valid,
  output logic                          link_last,
  input  logic                          link_ready,
  output logic                          has_flying_messages
);

  link_state_e            state_reg;
  logic [CH_W-1:0]        rr_ptr_reg;
  logic [FC_W-1:0]        flit_cnt_reg;
  logic [PKT_EXT_W-1:0]   pkt_reg;

  logic [NUM_CHANNELS-1:0] gnt;
  logic [CH_W-1:0]         gnt_idx;
  logic                    last_flit;
  logic                    arb_en;
  logic                    grant;
  logic [CH_W-1:0]         rr_ptr_next;

  assign last_flit = (flit_cnt_reg == FC_W'(FLITS - 1));
  // Arbitrate when idle, or on the final flit handshake so packets run back to back.
  // Gated by reset so no pop strobe reaches a FIFO while the link is held in reset.
  assign arb_en = reset && ((state_reg == IDLE) || (link_ready && last_flit));

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req     (ch_valid),
    .ptr     (rr_ptr_reg),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant       = |gnt;
  assign ch_ready    = gnt;
  assign rr_ptr_next = (gnt_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      flit_cnt_reg <= '0;
      pkt_reg      <= '0;
    end else begin
      if (grant) begin
        pkt_reg      <= PKT_EXT_W'({ch_data[gnt_idx*MFW +: MFW], gnt_idx});
        flit_cnt_reg <= '0;
        rr_ptr_reg   <= rr_ptr_next;
        state_reg    <= SEND;
      end else if (state_reg == SEND && link_ready) begin
        if (last_flit) begin
          flit_cnt_reg <= '0;
          state_reg    <= IDLE;
        end else begin
          flit_cnt_reg <= flit_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign link_valid          = (state_reg == SEND);
  assign link_last           = link_valid && last_flit;
  assign link_data           = link_valid ? pkt_reg[flit_cnt_reg*LINK_WIDTH +: LINK_WIDTH] : '0;
  assign has_flying_messages = (|ch_valid) || link_valid;

endmodule
